// File: rtl/seq_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : seq_add_sub
// Description : Digit-serial adder/subtractor. Two DATA_WD-bit operands are
//               accepted over a valid/ready handshake and summed CHUNK_WD bits
//               per clock, least-significant chunk first, with the carry
//               between chunks held in a register. The result is presented
//               on a second valid/ready handshake and held under backpressure.
//               Subtraction is A + ~B + ~i_c (bit DATA_WD = not-borrow).
// Ports       :
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      operand request valid
//   o_ready      operands can be accepted (IDLE only)
//   i_a, i_b     operands
//   i_c          carry-in (add) / borrow-in (sub)
//   i_sub        0 = A+B+c, 1 = A-B-c
//   o_valid      result valid (DONE only)
//   i_ready      downstream accepts the result
//   o_arith_out  {carry/not-borrow, DATA_WD-bit result}
//   o_ovf        two's-complement signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module seq_add_sub #(
    parameter int DATA_WD  = 16,
    parameter int CHUNK_WD = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_WD-1:0] i_a,
    input  logic [DATA_WD-1:0] i_b,
    input  logic               i_c,
    input  logic               i_sub,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_WD:0]   o_arith_out,
    output logic               o_ovf
);

    localparam int NUM_CHUNKS = DATA_WD / CHUNK_WD;
    localparam int CNT_WD     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if ((CHUNK_WD < 1) || ((DATA_WD % CHUNK_WD) != 0)) begin : g_chunk_check
        $error("seq_add_sub: CHUNK_WD must divide DATA_WD exactly");
    end

    logic [1:0]          r_state;
    logic [DATA_WD-1:0]  r_a;        // shifts right one chunk per BUSY cycle
    logic [DATA_WD-1:0]  r_b;        // effective B (inverted for subtract), shifts likewise
    logic                r_carry;
    logic [CNT_WD-1:0]   r_cnt;
    logic [DATA_WD-1:0]  r_sum;      // partial result, fills from the top down
    logic [DATA_WD:0]    r_arith_out;
    logic                r_ovf;

    logic [CHUNK_WD:0]          w_chunk_sum;
    logic [DATA_WD+CHUNK_WD-1:0] w_sum_cat;
    logic [DATA_WD-1:0]         w_sum_next;
    logic                       w_last;

    // Operands are shifted so the active chunk is always at bit 0; this keeps
    // every select constant and makes CHUNK_WD == DATA_WD work unchanged.
    assign w_chunk_sum = {1'b0, r_a[CHUNK_WD-1:0]} + {1'b0, r_b[CHUNK_WD-1:0]}
                       + {{CHUNK_WD{1'b0}}, r_carry};

    // New chunk enters at the top; after NUM_CHUNKS shifts chunk 0 sits at
    // bit 0 and the result is in natural order.
    assign w_sum_cat  = {w_chunk_sum[CHUNK_WD-1:0], r_sum};
    assign w_sum_next = w_sum_cat[DATA_WD+CHUNK_WD-1:CHUNK_WD];

    assign w_last = (r_cnt == CNT_WD'(NUM_CHUNKS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_arith_out <= '0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub ? ~i_c : i_c;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_a     <= r_a >> CHUNK_WD;
                    r_b     <= r_b >> CHUNK_WD;
                    r_sum   <= w_sum_next;
                    r_carry <= w_chunk_sum[CHUNK_WD];
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_arith_out <= {w_chunk_sum[CHUNK_WD], w_sum_next};
                        // On the last chunk bit CHUNK_WD-1 of the shifted
                        // operands is the original operand sign bit.
                        r_ovf       <= (r_a[CHUNK_WD-1] == r_b[CHUNK_WD-1]) &&
                                       (w_chunk_sum[CHUNK_WD-1] != r_a[CHUNK_WD-1]);
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_WD'(1);
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready     = (r_state == S_IDLE);
    assign o_valid     = (r_state == S_DONE);
    assign o_arith_out = r_arith_out;
    assign o_ovf       = r_ovf;

endmodule
`default_nettype wire
